// File: rtl/mul8_sequencer_pkg.sv
// Shared encodings and widths for the time-shared 8x8 multiplier.
package mul8_sequencer_pkg;

  localparam int OPW = 8;
  localparam int PW  = 16;
  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul8_sequencer_array4x4.sv
// Combinational 4x4 unsigned array multiplier: AND rows summed with shifts.
module mul8_sequencer_array4x4
  import mul8_sequencer_pkg::*;
(
  input  logic [NIB-1:0]   x,
  input  logic [NIB-1:0]   y,
  output logic [2*NIB-1:0] prod
);

  // Accumulate one gated, shifted copy of x per bit of y.
  always_comb begin
    prod = 8'd0;
    for (int i = 0; i < NIB; i++) begin
      prod = prod + ({4'd0, x & {NIB{y[i]}}} << i);
    end
  end

endmodule

// File: rtl/mul8_sequencer.sv
// 8x8 unsigned multiplier that reuses one 4x4 array over four STEP cycles,
// with valid/ready handshakes on the operand and product sides.
module mul8_sequencer
  import mul8_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p
);

  state_t          state;
  logic [1:0]      k;
  logic [OPW-1:0]  a_q;
  logic [OPW-1:0]  b_q;
  logic [PW-1:0]   acc;
  logic [NIB-1:0]  nib_a;
  logic [NIB-1:0]  nib_b;
  logic [2*NIB-1:0] prod;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   acc_next;

  // Select operand nibbles for step k and align the partial product.
  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    pp    = 16'd0;
    case (k)
      2'd0: begin
        nib_a = a_q[3:0];
        nib_b = b_q[3:0];
        pp    = {8'd0, prod};
      end
      2'd1: begin
        nib_a = a_q[7:4];
        nib_b = b_q[3:0];
        pp    = {4'd0, prod, 4'd0};
      end
      2'd2: begin
        nib_a = a_q[3:0];
        nib_b = b_q[7:4];
        pp    = {4'd0, prod, 4'd0};
      end
      2'd3: begin
        nib_a = a_q[7:4];
        nib_b = b_q[7:4];
        pp    = {prod, 8'd0};
      end
      default: begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        pp    = 16'd0;
      end
    endcase
  end

  assign acc_next = acc + pp;

  mul8_sequencer_array4x4 array4x4 (
    .x    (nib_a),
    .y    (nib_b),
    .prod (prod)
  );

  // Control FSM with registered handshake outputs; p is kept across IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 2'd0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      acc       <= 16'd0;
      p         <= 16'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            acc      <= 16'd0;
            k        <= 2'd0;
            in_ready <= 1'b0;
            state    <= STEP;
          end
        end
        STEP: begin
          acc <= acc_next;
          k   <= k + 2'd1;
          if (k == 2'd3) begin
            p         <= acc_next;
            out_valid <= 1'b1;
            k         <= 2'd0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          k         <= 2'd0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
